uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Serial receiver that turns the synchronized UART RX line on the Basys3 top level into bytes for the mic1 SoC.
- Sits directly downstream of the RX synchronizer and upstream of the SoC's serial input port.
- Frame format: 8N1, LSB first, mid-bit sampling.
- Received bytes are buffered in a small first-word-fall-through FIFO with a valid/ready consumer handshake.
- Framing and overrun errors are reported as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 52, clk cycles per bit period (6 MHz / 115200 baud); must be >= 4.
- FIFO_DEPTH, 4, byte entries; must be a power of two, >= 2.

Ports:
- clk  input  1  system clock
- resetn  input  1  reset, synchronous, active-low
- rx  input  1  serial line, already synchronized to clk; idles high
- rx_data  output  8  byte at FIFO head; meaningful only while rx_valid=1
- rx_valid  output  1  FIFO not empty
- rx_ready  input  1  consumer accepts the head byte
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: good byte dropped because FIFO full
- busy  output  1  receiver is inside a frame (any state except IDLE)
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=IDLE; FIFO emptied (level=0); rx_valid=0, rx_data=0.
  - frame_err=0, overrun=0, busy=0.
  - Previous-rx register set to 1.
  - Reset mid-frame aborts the frame; the partial byte is discarded.
- Definitions:
  - HALF = CLKS_PER_BIT/2, integer division.
  - t0 = the cycle where rx=0 and previous-rx=1.
- States:
  - IDLE: wait for a falling edge (t0) -> START.
  - START: sample rx at t0+HALF. If rx=1 it is a glitch -> IDLE, no error. Otherwise -> DATA.
  - DATA: sample bit i (i=0..7, LSB first) at t0+HALF+(i+1)*CLKS_PER_BIT into a shift register, then -> STOP.
  - STOP: sample rx at t0+HALF+9*CLKS_PER_BIT.
    - rx=1: byte pushed to FIFO -> IDLE.
    - rx=0: frame_err pulses on the following cycle, byte discarded -> WAIT_HIGH.
  - WAIT_HIGH: remain until rx=1 -> IDLE. A line held low (break) therefore yields exactly one frame_err.
- Re-arm: IDLE is re-entered on the cycle after the stop sample (mid stop bit), so back-to-back frames are received.
- FIFO:
  - rx_valid and the new rx_data appear on the cycle after the stop sample when the FIFO was empty (first-word fall-through).
  - Pop occurs on a cycle with rx_valid && rx_ready; the next entry (if any) appears on the following cycle.
  - rx_ready while rx_valid=0 has no effect.
- Push with FIFO full: the byte is dropped, overrun pulses on the next cycle, and FIFO contents are unchanged.
  - Exception: a pop in the same cycle frees a slot, so the push is accepted, level is unchanged, and there is no overrun.
- Push and pop in the same cycle (not full): level is unchanged, order is preserved.
- Pointers wrap modulo FIFO_DEPTH.
- level counts 0..FIFO_DEPTH.
- frame_err and overrun never assert in the same cycle and are never asserted for more than one cycle per frame.

Test Plan:
- CLKS_PER_BIT=8, FIFO_DEPTH=4; send 0xA5, rx_ready=1 -> rx_valid rises at t0+77, rx_data=0xA5, level returns to 0 after one cycle, no error pulses.
- rx_ready=0; send 0x01,0x02,0x03,0x04,0x05 back-to-back -> level=4, overrun pulses once after the fifth frame; pops then return 0x01..0x04 in order.
- Frame with stop bit 0 (data 0x3C) -> frame_err pulses once, level stays 0. Then hold rx low for 30 bit times -> no further frame_err; after rx returns high, 0x55 is received correctly.
- 2-cycle low glitch on an idle line -> returns to IDLE at t0+4, busy deasserts, no byte, no error.
- Assert resetn=0 mid-DATA while the FIFO holds 2 bytes -> next cycle level=0, rx_valid=0, busy=0; the following frame 0x7E is received correctly.
- FIFO full with rx_ready=1 pulsed on the exact stop-sample cycle of an incoming 0x99 -> no overrun, level stays 4, 0x99 is last out.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver (LSB first, mid-bit sampling) feeding a
// first-word-fall-through byte FIFO with a valid/ready consumer handshake.
//
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   rx               serial line, synchronized to clk, idles high
//   rx_data/rx_valid FIFO head byte and not-empty flag
//   rx_ready         consumer accepts the head byte
//   frame_err        1-cycle pulse: stop bit sampled low
//   overrun          1-cycle pulse: good byte dropped, FIFO full
//   busy             receiver inside a frame
//   level            FIFO occupancy, 0..FIFO_DEPTH
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 52,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] HALF_M1 =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1 =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] DEPTH_L =
    (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          prev_q;
  logic          push_q, push_d;
  logic          fe_q, fe_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          push_ok;

  // Receiver state register. The stop-sample decision is held one
  // cycle in push_q / fe_q so the FIFO write and the error pulse
  // both land on the cycle after the stop sample.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      prev_q  <= 1'b1;
      push_q  <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      prev_q  <= rx;
      push_q  <= push_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    push_d  = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx && prev_q)
          state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          sh_d  = {rx, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7)
            state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          if (rx) begin
            push_d  = 1'b1;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) stays here, so it reports only once.
        cnt_d = '0;
        if (rx)
          state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign rx_valid = (count != '0);
  assign full     = (count == DEPTH_L);
  assign pop      = rx_valid && rx_ready;
  // A pop in the same cycle frees the slot a full FIFO lacks.
  assign push_ok  = push_q && (!full || pop);
  assign rx_data  = mem[rd_ptr];
  assign level    = count;

  // sh_q is stable while push_q is set: the receiver is back in
  // IDLE and cannot shift again for at least half a bit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= sh_q;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)
        count <= count + (AW+1)'(1);
      else if (!push_ok && pop)
        count <= count - (AW+1)'(1);
      overrun   <= push_q && full && !pop;
      frame_err <= fe_q;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo with a byte
// scoreboard queue checked on every consumer pop.
module tb_uart_rx_fifo;

  localparam int C = 8;
  localparam int D = 4;

  logic       clk;
  logic       resetn;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH(D)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_err(frame_err),
    .overrun(overrun),
    .busy(busy),
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Pops and error pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (resetn) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err || overrun)
        check("err_excl", {31'd0, frame_err & overrun}, 32'd0);
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", {24'd0, rx_data}, 32'hFFFF);
        end else begin
          check("pop_data", {24'd0, rx_data},
                {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic stp);
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (C) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (C) @(posedge clk);
    end
    #1 rx = stp;
    repeat (C) @(posedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    #1 rx_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1 rx_ready = 1'b0;
    check("drain_q", exp_q.size(), 32'd0);
    @(posedge clk);
    #1 check("drain_lvl", {29'd0, level}, 32'd0);
  endtask

  initial begin
    resetn   = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_lvl", {29'd0, level}, 32'd0);
    check("rst_vld", {31'd0, rx_valid}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fe", {31'd0, frame_err}, 32'd0);
    check("rst_ov", {31'd0, overrun}, 32'd0);
    resetn = 1'b1;
    repeat (3) @(posedge clk);

    // single byte, latency to rx_valid
    #1 rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    fork
      send(8'hA5, 1'b1);
      begin
        @(posedge clk);
        repeat (77) @(posedge clk);
        #1 check("lat_pre", {31'd0, rx_valid}, 32'd0);
        @(posedge clk);
        #1 check("lat_vld", {31'd0, rx_valid}, 32'd1);
        check("lat_data", {24'd0, rx_data}, 32'hA5);
        check("lat_lvl", {29'd0, level}, 32'd1);
        @(posedge clk);
        #1 check("lat_lvl0", {29'd0, level}, 32'd0);
      end
    join
    repeat (4) @(posedge clk);
    check("a5_fe", fe_cnt, 32'd0);
    check("a5_ov", ov_cnt, 32'd0);
    check("a5_q", exp_q.size(), 32'd0);

    // fill and overrun
    #1 rx_ready = 1'b0;
    ov_cnt = 0;
    for (int i = 1; i <= 4; i++)
      exp_q.push_back(8'(i));
    for (int i = 1; i <= 5; i++)
      send(8'(i), 1'b1);
    repeat (4) @(posedge clk);
    #1 check("ovr_lvl", {29'd0, level}, 32'd4);
    check("ovr_cnt", ov_cnt, 32'd1);
    drain();

    // framing error then break
    fe_cnt = 0;
    send(8'h3C, 1'b0);
    repeat (30 * C) @(posedge clk);
    #1 rx = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("fe_cnt", fe_cnt, 32'd1);
    check("fe_lvl", {29'd0, level}, 32'd0);
    check("fe_busy", {31'd0, busy}, 32'd0);
    rx_ready = 1'b1;
    exp_q.push_back(8'h55);
    send(8'h55, 1'b1);
    repeat (4) @(posedge clk);
    #1 check("brk_q", exp_q.size(), 32'd0);
    check("brk_fe", fe_cnt, 32'd1);
    rx_ready = 1'b0;

    // short glitch
    fe_cnt = 0;
    ov_cnt = 0;
    @(posedge clk);
    #1 rx = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rx = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("gl_busy1", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1 check("gl_busy0", {31'd0, busy}, 32'd0);
    repeat (C * 2) @(posedge clk);
    #1 check("gl_lvl", {29'd0, level}, 32'd0);
    check("gl_err", fe_cnt + ov_cnt, 32'd0);

    // reset mid-frame with two bytes held
    send(8'h12, 1'b1);
    send(8'h34, 1'b1);
    repeat (2) @(posedge clk);
    #1 check("mr_lvl2", {29'd0, level}, 32'd2);
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (C + C / 2 + 2 * C) @(posedge clk);
    #1 check("mr_busy", {31'd0, busy}, 32'd1);
    resetn = 1'b0;
    rx = 1'b1;
    @(posedge clk);
    #1 check("mr_lvl", {29'd0, level}, 32'd0);
    check("mr_vld", {31'd0, rx_valid}, 32'd0);
    check("mr_busy0", {31'd0, busy}, 32'd0);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1 rx_ready = 1'b1;
    exp_q.push_back(8'h7E);
    send(8'h7E, 1'b1);
    repeat (4) @(posedge clk);
    #1 check("mr_q", exp_q.size(), 32'd0);
    rx_ready = 1'b0;

    // full FIFO, pop on the stop-sample edge
    ov_cnt = 0;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    send(8'h44, 1'b1);
    #1 check("pf_lvl4", {29'd0, level}, 32'd4);
    exp_q.push_back(8'h99);
    fork
      send(8'h99, 1'b1);
      begin
        @(posedge clk);
        repeat (76) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    repeat (2) @(posedge clk);
    #1 check("pf_ov", ov_cnt, 32'd0);
    check("pf_lvl", {29'd0, level}, 32'd4);
    check("pf_q", exp_q.size(), 32'd4);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
